// File: rtl/dip_linebuf_stream.sv
// Multi-line pixel buffer: emits a vertical column of NUM_LINES+1 pixels per
// accepted raster pixel, with row/column tracking and masking of unfilled lines.
module dip_linebuf_stream #(
  parameter int DATA_W    = 8,
  parameter int IMG_W     = 640,
  parameter int NUM_LINES = 2,
  parameter int ADDR_W    = $clog2(IMG_W)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sof_i,
  input  logic                            pix_vld_i,
  input  logic [DATA_W-1:0]               pix_i,
  output logic                            tap_vld_o,
  output logic [(NUM_LINES+1)*DATA_W-1:0] tap_o,
  output logic                            tap_full_o,
  output logic [ADDR_W-1:0]               col_o,
  output logic [15:0]                     row_o,
  output logic                            eol_o
);

  localparam int FILL_W = $clog2(NUM_LINES + 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(NUM_LINES);

  logic [DATA_W-1:0] mem  [NUM_LINES][IMG_W];
  logic [DATA_W-1:0] rd_q [NUM_LINES];

  logic [ADDR_W-1:0] col_q, col_eff, col_nxt;
  logic [15:0]       row_q, row_eff, row_nxt;
  logic [FILL_W-1:0] fill_q, fill_eff, fill_nxt;
  logic              wrap;
  logic [DATA_W-1:0] pix_q;
  logic [NUM_LINES:1] mask_q;

  // A start-of-frame pixel overrides the tracked position before it is used.
  always_comb begin
    col_eff  = sof_i ? '0 : col_q;
    row_eff  = sof_i ? '0 : row_q;
    fill_eff = sof_i ? '0 : fill_q;
    wrap     = (col_eff == LAST_COL);
    col_nxt  = wrap ? '0 : col_eff + 1'b1;
    row_nxt  = (wrap && row_eff != '1) ? row_eff + 16'd1 : row_eff;
    fill_nxt = (wrap && fill_eff != FULL_FILL) ? fill_eff + 1'b1 : fill_eff;
  end

  // Banks are cascaded: each one takes the pre-write contents of the one below.
  always_ff @(posedge clk) begin
    if (pix_vld_i) begin
      for (int unsigned k = 0; k < NUM_LINES; k++) begin
        rd_q[k] <= mem[k][col_eff];
        if (k == 0) mem[k][col_eff] <= pix_i;
        else        mem[k][col_eff] <= mem[k-1][col_eff];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      fill_q     <= '0;
      tap_vld_o  <= 1'b0;
      pix_q      <= '0;
      mask_q     <= '0;
      col_o      <= '0;
      row_o      <= '0;
      eol_o      <= 1'b0;
      tap_full_o <= 1'b0;
    end else begin
      tap_vld_o <= pix_vld_i;
      if (pix_vld_i) begin
        col_q      <= col_nxt;
        row_q      <= row_nxt;
        fill_q     <= fill_nxt;
        pix_q      <= pix_i;
        col_o      <= col_eff;
        row_o      <= row_eff;
        eol_o      <= wrap;
        tap_full_o <= (fill_eff == FULL_FILL);
        for (int unsigned k = 1; k <= NUM_LINES; k++)
          mask_q[k] <= (32'(fill_eff) >= k);
      end
    end
  end

  always_comb begin
    tap_o = '0;
    tap_o[DATA_W-1:0] = pix_q;
    for (int unsigned k = 1; k <= NUM_LINES; k++)
      tap_o[k*DATA_W +: DATA_W] = mask_q[k] ? rd_q[k-1] : '0;
  end

endmodule

// File: tb/tb_dip_linebuf_stream.sv
// Directed bench for dip_linebuf_stream: small-image vector table plus
// a wide-image run against a frame-array reference.
module tb_dip_linebuf_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof, pix_vld;
  logic [7:0]  pix;
  logic        tap_vld, tap_full, eol;
  logic [23:0] tap;
  logic [1:0]  col;
  logic [15:0] row;

  logic        b_sof, b_vld;
  logic [7:0]  b_pix;
  logic        b_tap_vld, b_full, b_eol;
  logic [39:0] b_tap;
  logic [9:0]  b_col;
  logic [15:0] b_row;

  int n_tests = 0;
  int n_fail  = 0;
  int vld_cnt = 0;

  always #5 clk = ~clk;

  dip_linebuf_stream #(.DATA_W(8), .IMG_W(4), .NUM_LINES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sof_i(sof), .pix_vld_i(pix_vld), .pix_i(pix),
    .tap_vld_o(tap_vld), .tap_o(tap), .tap_full_o(tap_full),
    .col_o(col), .row_o(row), .eol_o(eol)
  );

  dip_linebuf_stream #(.DATA_W(8), .IMG_W(640), .NUM_LINES(4)) dut_big (
    .clk(clk), .rst_n(rst_n), .sof_i(b_sof), .pix_vld_i(b_vld), .pix_i(b_pix),
    .tap_vld_o(b_tap_vld), .tap_o(b_tap), .tap_full_o(b_full),
    .col_o(b_col), .row_o(b_row), .eol_o(b_eol)
  );

  always @(negedge clk) if (tap_vld) vld_cnt++;

  typedef struct {
    logic        sof;
    logic [7:0]  pix;
    logic [23:0] tap;
    logic [1:0]  col;
    logic [15:0] row;
    logic        eol;
    logic        full;
  } vec_t;

  vec_t vec [12];
  logic [7:0] img [8][640];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic accept(input logic s, input logic [7:0] p);
    @(negedge clk);
    sof = s; pix_vld = 1'b1; pix = p;
    @(posedge clk); #1;
    sof = 1'b0; pix_vld = 1'b0;
  endtask

  task automatic check_tap(input string tag, input logic [23:0] t, input logic [1:0] c,
                           input logic [15:0] r, input logic e, input logic f);
    check({tag, "_vld"},  64'(tap_vld), 64'(1'b1));
    check({tag, "_tap"},  64'(tap), 64'(t));
    check({tag, "_col"},  64'(col), 64'(c));
    check({tag, "_row"},  64'(row), 64'(r));
    check({tag, "_eol"},  64'(eol), 64'(e));
    check({tag, "_full"}, 64'(tap_full), 64'(f));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"},  64'(tap_vld), 64'(0));
    check({tag, "_tap"},  64'(tap), 64'(0));
    check({tag, "_col"},  64'(col), 64'(0));
    check({tag, "_row"},  64'(row), 64'(0));
    check({tag, "_eol"},  64'(eol), 64'(0));
    check({tag, "_full"}, 64'(tap_full), 64'(0));
  endtask

  initial begin
    int cnt0;
    int gap;
    logic [39:0] exp;

    vec[0]  = '{1'b1, 8'h01, 24'h000001, 2'd0, 16'd0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 8'h02, 24'h000002, 2'd1, 16'd0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 8'h03, 24'h000003, 2'd2, 16'd0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 8'h04, 24'h000004, 2'd3, 16'd0, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 8'h05, 24'h000105, 2'd0, 16'd1, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 8'h06, 24'h000206, 2'd1, 16'd1, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 8'h07, 24'h000307, 2'd2, 16'd1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 8'h08, 24'h000408, 2'd3, 16'd1, 1'b1, 1'b0};
    vec[8]  = '{1'b0, 8'h09, 24'h010509, 2'd0, 16'd2, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 8'h0A, 24'h02060A, 2'd1, 16'd2, 1'b0, 1'b1};
    vec[10] = '{1'b0, 8'h0B, 24'h03070B, 2'd2, 16'd2, 1'b0, 1'b1};
    vec[11] = '{1'b0, 8'h0C, 24'h04080C, 2'd3, 16'd2, 1'b1, 1'b1};

    rst_n = 1'b0; sof = 1'b0; pix_vld = 1'b0; pix = '0;
    b_sof = 1'b0; b_vld = 1'b0; b_pix = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Contiguous stream
    for (int i = 0; i < 12; i++) begin
      accept(vec[i].sof, vec[i].pix);
      check_tap($sformatf("t1_%0d", i), vec[i].tap, vec[i].col, vec[i].row, vec[i].eol, vec[i].full);
    end
    @(posedge clk); #1;
    check("t1_vld_drop", 64'(tap_vld), 64'(0));

    // Same stream with idle gaps; outputs must hold while idle
    cnt0 = vld_cnt;
    for (int i = 0; i < 12; i++) begin
      accept(vec[i].sof, vec[i].pix);
      check_tap($sformatf("t2_%0d", i), vec[i].tap, vec[i].col, vec[i].row, vec[i].eol, vec[i].full);
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        check("t2_gap_vld", 64'(tap_vld), 64'(0));
        check("t2_gap_hold", 64'({tap, col, row, eol, tap_full}),
              64'({vec[i].tap, vec[i].col, vec[i].row, vec[i].eol, vec[i].full}));
      end
    end
    @(posedge clk); #1;
    check("t2_vld_count", 64'(vld_cnt - cnt0), 64'(12));

    // Mid-line start of frame: stale banks must stay hidden
    accept(1'b0, 8'h0D);
    check_tap("t3_r3c0", 24'h05090D, 2'd0, 16'd3, 1'b0, 1'b1);
    accept(1'b0, 8'h0E);
    accept(1'b1, 8'hAA);
    check_tap("t3_sof", 24'h0000AA, 2'd0, 16'd0, 1'b0, 1'b0);
    accept(1'b0, 8'hB1);
    accept(1'b0, 8'hB2);
    accept(1'b0, 8'hB3);
    check_tap("t3_r0c3", 24'h0000B3, 2'd3, 16'd0, 1'b1, 1'b0);
    accept(1'b0, 8'hC0);
    check_tap("t3_r1c0", 24'h00AAC0, 2'd0, 16'd1, 1'b0, 1'b0);
    accept(1'b0, 8'hC1);
    check_tap("t3_r1c1", 24'h00B1C1, 2'd1, 16'd1, 1'b0, 1'b0);

    // Asynchronous reset mid-row
    @(negedge clk) rst_n = 1'b0;
    #1 check_zero("t4_rst");
    @(negedge clk) rst_n = 1'b1;
    accept(1'b0, 8'h33);
    check_tap("t4_after", 24'h000033, 2'd0, 16'd0, 1'b0, 1'b0);

    // Wide image, back-to-back frames (8 rows, then 2 rows of a new frame)
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < (f == 0 ? 8 : 2); r++) begin
        for (int c = 0; c < 640; c++) begin
          @(negedge clk);
          img[r][c] = 8'($urandom);
          b_sof = (r == 0 && c == 0);
          b_vld = 1'b1;
          b_pix = img[r][c];
          @(posedge clk); #1;
          exp = '0;
          for (int k = 0; k <= 4; k++)
            if (r >= k) exp[k*8 +: 8] = img[r-k][c];
          check("t5_tap", 64'(b_tap), 64'(exp));
          check("t5_meta", 64'({b_tap_vld, b_col, b_row, b_eol, b_full}),
                64'({1'b1, 10'(c), 16'(r), (c == 639), (r >= 4)}));
        end
      end
    end
    b_vld = 1'b0; b_sof = 1'b0;
    @(posedge clk); #1;
    check("t5_vld_drop", 64'(b_tap_vld), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
